// File: rtl/act_tile_buffer_if.sv
// Handshake/bus bundle for act_tile_buffer: load-side strobes plus the streaming beat outputs.
interface act_tile_buffer_if #(
    parameter int ROWS       = 8,
    parameter int ACT_W      = 7,
    parameter int TILES      = 8,
    parameter int COMP_GROUP = 3
);
    localparam int COMP_SLOTS = ROWS * COMP_GROUP;
    localparam int AW = (ROWS * TILES > 1) ? $clog2(ROWS * TILES) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int TW = (TILES > 1) ? $clog2(TILES) : 1;

    logic                        wr_en;
    logic [AW-1:0]               wr_addr;
    logic [ACT_W-1:0]            wr_data;
    logic                        comp_valid;
    logic [RW-1:0]               comp_row;
    logic                        col_change;
    logic                        start;
    logic                        act_valid;
    logic                        act_ready;
    logic [ROWS*ACT_W-1:0]       act_out;
    logic [COMP_SLOTS*ACT_W-1:0] comp_out;
    logic [COMP_SLOTS-1:0]       comp_mask;
    logic [TW-1:0]               tile_idx;
    logic                        done;
    logic                        comp_ovf;

    modport master (
        output wr_en, wr_addr, wr_data, comp_valid, comp_row, col_change, start, act_ready,
        input  act_valid, act_out, comp_out, comp_mask, tile_idx, done, comp_ovf
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, comp_valid, comp_row, col_change, start, act_ready,
        output act_valid, act_out, comp_out, comp_mask, tile_idx, done, comp_ovf
    );
endinterface

// File: rtl/act_tile_buffer.sv
// Activation tile buffer: loads a TILES x ROWS block, then streams one ROWS-wide vector per beat.
// Compensation slots are built only when ACT_TILE_BUFFER_COMP_EN is defined.
module act_tile_buffer #(
    parameter int ROWS       = 8,
    parameter int ACT_W      = 7,
    parameter int TILES      = 8,
    parameter int COMP_GROUP = 3
) (
    input logic              clk,
    input logic              rst,
    act_tile_buffer_if.slave bus
);
    localparam int COMP_SLOTS = ROWS * COMP_GROUP;
    localparam int DEPTH      = ROWS * TILES;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int TW = (TILES > 1) ? $clog2(TILES) : 1;

    typedef enum logic [1:0] {LOAD, STREAM, DONE} state_e;

    state_e           state_q, state_d;
    logic [TW-1:0]    tptr_q, tptr_d;
    logic [ACT_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            tptr_q  <= '0;
        end else begin
            state_q <= state_d;
            tptr_q  <= tptr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        tptr_d        = tptr_q;
        bus.act_valid = 1'b0;
        bus.done      = 1'b0;
        case (state_q)
            LOAD: begin
                if (bus.start) begin
                    state_d = STREAM;
                    tptr_d  = '0;
                end
            end
            STREAM: begin
                bus.act_valid = 1'b1;
                if (bus.act_ready) begin
                    if (tptr_q == TW'(TILES - 1)) state_d = DONE;
                    else                          tptr_d  = tptr_q + 1'b1;
                end
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = LOAD;
                tptr_d   = '0;
            end
            default: state_d = LOAD;
        endcase
    end

    // Activation storage has no reset; start wins over a write landing in the same cycle.
    always_ff @(posedge clk) begin
        if (state_q == LOAD && bus.wr_en && !bus.start)
            mem_q[bus.wr_addr] <= bus.wr_data;
    end

    always_comb begin
        bus.act_out = '0;
        for (int r = 0; r < ROWS; r++)
            bus.act_out[r*ACT_W +: ACT_W] = mem_q[AW'(int'(tptr_q) * ROWS + r)];
    end

    assign bus.tile_idx = tptr_q;

`ifdef ACT_TILE_BUFFER_COMP_EN
    localparam int SW  = $clog2(COMP_GROUP + 1);
    localparam int SSW = (COMP_SLOTS > 1) ? $clog2(COMP_SLOTS) : 1;

    logic [RW-1:0]         slot_row_q [COMP_SLOTS];
    logic [RW-1:0]         slot_row_d [COMP_SLOTS];
    logic [COMP_SLOTS-1:0] mask_q, mask_d;
    logic [RW-1:0]         col_q, col_d;
    logic [SW-1:0]         sub_q, sub_d;
    logic                  ovf_q, ovf_d;
    logic [SSW-1:0]        slot_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < COMP_SLOTS; s++) slot_row_q[s] <= '0;
            mask_q <= '0;
            col_q  <= '0;
            sub_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            slot_row_q <= slot_row_d;
            mask_q     <= mask_d;
            col_q      <= col_d;
            sub_q      <= sub_d;
            ovf_q      <= ovf_d;
        end
    end

    // The row is recorded into the current column before a same-cycle column advance.
    always_comb begin
        slot_row_d = slot_row_q;
        mask_d     = mask_q;
        col_d      = col_q;
        sub_d      = sub_q;
        ovf_d      = ovf_q;
        slot_sel   = SSW'(int'(col_q) * COMP_GROUP + int'(sub_q));
        if (state_q == DONE) begin
            for (int s = 0; s < COMP_SLOTS; s++) slot_row_d[s] = '0;
            mask_d = '0;
            col_d  = '0;
            sub_d  = '0;
            ovf_d  = 1'b0;
        end else if (state_q == LOAD) begin
            if (bus.comp_valid) begin
                if (sub_q == SW'(COMP_GROUP)) begin
                    ovf_d = 1'b1;
                end else begin
                    slot_row_d[slot_sel] = bus.comp_row;
                    mask_d[slot_sel]     = 1'b1;
                    sub_d                = sub_q + 1'b1;
                end
            end
            if (bus.col_change && col_q != RW'(ROWS - 1)) begin
                col_d = col_q + 1'b1;
                sub_d = '0;
            end
        end
    end

    always_comb begin
        bus.comp_out = '0;
        for (int s = 0; s < COMP_SLOTS; s++)
            if (mask_q[s])
                bus.comp_out[s*ACT_W +: ACT_W] =
                    mem_q[AW'(int'(tptr_q) * ROWS + int'(slot_row_q[s]))];
    end

    assign bus.comp_mask = mask_q;
    assign bus.comp_ovf  = ovf_q;
`else
    logic unused_comp;
    assign unused_comp   = ^{bus.comp_valid, bus.comp_row, bus.col_change};
    assign bus.comp_out  = '0;
    assign bus.comp_mask = {COMP_SLOTS{1'b0}};
    assign bus.comp_ovf  = 1'b0;
`endif
endmodule

// File: tb/tb_act_tile_buffer.sv
// Self-checking bench for act_tile_buffer: directed scenarios plus randomized load/stream rounds
// compared every cycle against a behavioural model of the buffer.
module tb_act_tile_buffer;
    localparam int ROWS  = 8;
    localparam int ACT_W = 7;
    localparam int TILES = 8;
    localparam int CG    = 3;
    localparam int SLOTS = ROWS * CG;
    localparam int DEPTH = ROWS * TILES;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    act_tile_buffer_if #(.ROWS(ROWS), .ACT_W(ACT_W), .TILES(TILES), .COMP_GROUP(CG)) bus ();

    act_tile_buffer #(.ROWS(ROWS), .ACT_W(ACT_W), .TILES(TILES), .COMP_GROUP(CG)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    bit cmpEn = 1'b0;

    logic [ACT_W-1:0] mMem [DEPTH];
    bit               mKnown [DEPTH];
    bit               mStreaming;
    bit               mDonePulse;
    int               mTile;
    int               mColRow [ROWS][CG];
    int               mColCount [ROWS];
    int               mCol;
    bit               mOvf;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clearComp();
        for (int c = 0; c < ROWS; c++) mColCount[c] = 0;
        mCol = 0;
        mOvf = 1'b0;
    endtask

    task automatic modelReset();
        mStreaming = 1'b0;
        mDonePulse = 1'b0;
        mTile      = 0;
        clearComp();
    endtask

    // Advance the model by one clock edge given the inputs held during that cycle.
    task automatic modelStep(input bit we, input int addr, input int data, input bit cv,
                             input int row, input bit cc, input bit st, input bit rdy);
        logic [ACT_W-1:0] d;
        d = data[ACT_W-1:0];
        if (mDonePulse) begin
            mDonePulse = 1'b0;
            mTile      = 0;
            clearComp();
        end else if (mStreaming) begin
            if (rdy) begin
                if (mTile == TILES - 1) begin
                    mStreaming = 1'b0;
                    mDonePulse = 1'b1;
                end else begin
                    mTile++;
                end
            end
        end else begin
            if (st) begin
                mStreaming = 1'b1;
                mTile      = 0;
            end else if (we) begin
                mMem[addr]   = d;
                mKnown[addr] = 1'b1;
            end
`ifdef ACT_TILE_BUFFER_COMP_EN
            if (cv) begin
                if (mColCount[mCol] == CG) mOvf = 1'b1;
                else begin
                    mColRow[mCol][mColCount[mCol]] = row;
                    mColCount[mCol]++;
                end
            end
            if (cc && mCol < ROWS - 1) mCol++;
`endif
        end
    endtask

    task automatic applyStimulus(input bit we, input int addr, input int data, input bit cv,
                                 input int row, input bit cc, input bit st, input bit rdy);
        bus.wr_en      = we;
        bus.wr_addr    = addr[5:0];
        bus.wr_data    = data[ACT_W-1:0];
        bus.comp_valid = cv;
        bus.comp_row   = row[2:0];
        bus.col_change = cc;
        bus.start      = st;
        bus.act_ready  = rdy;
        @(posedge clk);
        modelStep(we, addr, data, cv, row, cc, st, rdy);
        #1;
    endtask

    function automatic bit actKnown(input int tile);
        bit k = 1'b1;
        for (int r = 0; r < ROWS; r++) if (!mKnown[tile*ROWS + r]) k = 1'b0;
        return k;
    endfunction

    function automatic logic [255:0] expAct(input int tile);
        logic [255:0] v = '0;
        for (int r = 0; r < ROWS; r++) v[r*ACT_W +: ACT_W] = mMem[tile*ROWS + r];
        return v;
    endfunction

    function automatic logic [255:0] expMask();
        logic [255:0] v = '0;
        for (int s = 0; s < SLOTS; s++) if ((s % CG) < mColCount[s / CG]) v[s] = 1'b1;
        return v;
    endfunction

    function automatic logic [255:0] expComp(input int tile);
        logic [255:0] v = '0;
        for (int s = 0; s < SLOTS; s++)
            if ((s % CG) < mColCount[s / CG])
                v[s*ACT_W +: ACT_W] = mMem[tile*ROWS + mColRow[s / CG][s % CG]];
        return v;
    endfunction

    // Cycle-by-cycle comparison of every meaningful output against the model.
    always @(negedge clk) begin
        if (cmpEn && !rst) begin
            checkOutput("act_valid", 256'(bus.act_valid), 256'(mStreaming));
            checkOutput("done", 256'(bus.done), 256'(mDonePulse));
            checkOutput("comp_ovf", 256'(bus.comp_ovf), 256'(mOvf));
            checkOutput("comp_mask", 256'(bus.comp_mask), expMask());
            if (!mDonePulse) begin
                checkOutput("tile_idx", 256'(bus.tile_idx), 256'(mTile));
                if (actKnown(mTile)) begin
                    checkOutput("act_out", 256'(bus.act_out), expAct(mTile));
                    checkOutput("comp_out", 256'(bus.comp_out), expComp(mTile));
                end
            end
        end
    end

    function automatic logic [255:0] beatVec(input int t);
        logic [255:0] v = '0;
        for (int r = 0; r < ROWS; r++) v[r*ACT_W +: ACT_W] = ACT_W'(ROWS*t + r);
        return v;
    endfunction

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    logic [255:0] savedAct;
    bit           doneSeen;

    initial begin
        for (int a = 0; a < DEPTH; a++) mKnown[a] = 1'b0;
        modelReset();
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.comp_valid = 0;
        bus.comp_row = 0; bus.col_change = 0; bus.start = 0; bus.act_ready = 0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_act_valid", 256'(bus.act_valid), 256'(0));
        checkOutput("rst_done", 256'(bus.done), 256'(0));
        checkOutput("rst_comp_ovf", 256'(bus.comp_ovf), 256'(0));
        checkOutput("rst_comp_mask", 256'(bus.comp_mask), 256'(0));
        checkOutput("rst_tile_idx", 256'(bus.tile_idx), 256'(0));
        checkOutput("rst_comp_out", 256'(bus.comp_out), 256'(0));
        @(negedge clk); #1;
        rst   = 1'b0;
        cmpEn = 1'b1;

        // Load mem[a]=a while recording comp rows 5,2 (col 0) and 7 (col 1).
        for (int a = 0; a < DEPTH; a++)
            applyStimulus(1, a, a, (a == 0 || a == 1 || a == 3), (a == 0) ? 5 : (a == 1) ? 2 : 7,
                          (a == 2), 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("start_valid", 256'(bus.act_valid), 256'(1));
`ifdef ACT_TILE_BUFFER_COMP_EN
        checkOutput("mask_lit", 256'(bus.comp_mask), 256'(24'h00000B));
`endif
        for (int t = 0; t < TILES; t++) begin
            checkOutput("beat_lit", 256'(bus.act_out), beatVec(t));
            checkOutput("tile_lit", 256'(bus.tile_idx), 256'(t));
`ifdef ACT_TILE_BUFFER_COMP_EN
            checkOutput("slot0_lit", 256'(bus.comp_out[0*ACT_W +: ACT_W]), 256'(8*t + 5));
            checkOutput("slot1_lit", 256'(bus.comp_out[1*ACT_W +: ACT_W]), 256'(8*t + 2));
            checkOutput("slot3_lit", 256'(bus.comp_out[3*ACT_W +: ACT_W]), 256'(8*t + 7));
            checkOutput("slot2_lit", 256'(bus.comp_out[2*ACT_W +: ACT_W]), 256'(0));
`endif
            checkOutput("done_early", 256'(bus.done), 256'(0));
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        end
        checkOutput("done_lit", 256'(bus.done), 256'(1));
        checkOutput("done_valid", 256'(bus.act_valid), 256'(0));
        idle();
        checkOutput("done_pulse_end", 256'(bus.done), 256'(0));

        // Overflow: four comp_valid into column 0.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 1, i + 1, 0, 0, 0);
`ifdef ACT_TILE_BUFFER_COMP_EN
            checkOutput("ovf_lit", 256'(bus.comp_ovf), 256'(i == 3));
`endif
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        repeat (TILES) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("ovf_done", 256'(bus.done), 256'(1));
        idle();
        checkOutput("ovf_cleared", 256'(bus.comp_ovf), 256'(0));

        // Same-cycle comp_valid + col_change, then act_ready toggling 1,0,0,1.
        applyStimulus(0, 0, 0, 1, 4, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 6, 0, 0, 0);
`ifdef ACT_TILE_BUFFER_COMP_EN
        checkOutput("same_cyc_mask", 256'(bus.comp_mask), 256'(24'h000009));
`endif
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        savedAct = 256'(bus.act_out);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput("hold_tile", 256'(bus.tile_idx), 256'(1));
            checkOutput("hold_act", 256'(bus.act_out), savedAct);
            checkOutput("hold_act_lit", 256'(bus.act_out), beatVec(1));
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("resume_tile", 256'(bus.tile_idx), 256'(2));
        repeat (TILES - 2) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("toggle_done", 256'(bus.done), 256'(1));
        idle();

        // Reset after beat 3, then a fresh stream from tile 0.
        applyStimulus(0, 0, 0, 1, 3, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("midrst_valid", 256'(bus.act_valid), 256'(0));
        checkOutput("midrst_tile", 256'(bus.tile_idx), 256'(0));
        checkOutput("midrst_mask", 256'(bus.comp_mask), 256'(0));
        checkOutput("midrst_comp_out", 256'(bus.comp_out), 256'(0));
        @(negedge clk); #1;
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("fresh_tile", 256'(bus.tile_idx), 256'(0));
        checkOutput("fresh_act_lit", 256'(bus.act_out), beatVec(0));
        doneSeen = 1'b0;
        for (int k = 0; k < 100 && !doneSeen; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
            if (bus.done) doneSeen = 1'b1;
        end
        checkOutput("fresh_done_timeout", 256'(doneSeen), 256'(1));
        idle();

        // Randomized load/stream rounds, including ignored strobes while streaming.
        for (int round = 0; round < 8; round++) begin
            for (int c = 0; c < 30; c++)
                applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                              int'($urandom_range(0, 127)), ($urandom_range(0, 2) == 0),
                              int'($urandom_range(0, ROWS - 1)), ($urandom_range(0, 5) == 0), 0, 0);
            applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                          int'($urandom_range(0, 127)), 0, 0, 0, 1, 0);
            doneSeen = 1'b0;
            for (int k = 0; k < 200 && !doneSeen; k++) begin
                applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                              int'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
                              int'($urandom_range(0, ROWS - 1)), 1'($urandom_range(0, 1)),
                              ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
                if (bus.done) doneSeen = 1'b1;
            end
            checkOutput("rand_done_timeout", 256'(doneSeen), 256'(1));
            idle();
        end

        @(negedge clk);
        cmpEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
